// File: rtl/spi_master_pkg.sv
// Shared constants and types for the SPI master that drives the 10-bit-frame
// SPI slave / RAM subsystem.
package spi_master_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 5;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEAD      = 3'd1,
        ST_SHIFT_OUT = 3'd2,
        ST_RD_WAIT   = 3'd3,
        ST_SHIFT_IN  = 3'd4,
        ST_GAP       = 3'd5
    } state_e;

    // Phase counters count down to zero, so a phase of len cycles loads len-1.
    function automatic logic [CNT_W-1:0] phase_load(input int unsigned len);
        return (len == 0) ? '0 : CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Serialiser/deserialiser for the SPI master: 10-bit PISO feeding MOSI and
// 8-bit SIPO collecting MISO, both MSB first.
module spi_master_shifter
    import spi_master_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              shift_out_i,
    input  logic              shift_in_i,
    input  logic [CMD_W-1:0]  cmd_i,
    input  logic              miso_i,
    output logic              mosi_bit_o,
    output logic [DATA_W-1:0] rx_next_o
);

    logic [CMD_W-1:0]  tx_q;
    logic [DATA_W-1:0] rx_q;

    // A load that coincides with a shift presents cmd[9] now and keeps the rest.
    assign mosi_bit_o = load_i ? cmd_i[CMD_W-1] : tx_q[CMD_W-1];
    assign rx_next_o  = {rx_q[DATA_W-2:0], miso_i};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            if (load_i) begin
                tx_q <= shift_out_i ? {cmd_i[CMD_W-2:0], 1'b0} : cmd_i;
            end else if (shift_out_i) begin
                tx_q <= {tx_q[CMD_W-2:0], 1'b0};
            end
            if (shift_in_i) begin
                rx_q <= rx_next_o;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: accepts 10-bit host commands, frames them on SS_n/MOSI
// sharing CLK with the slave, and returns the MISO byte for read-data commands.
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int unsigned LEAD_CYCLES  = 1,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    input  logic              abort,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam state_e          GAP_STATE = (GAP_CYCLES != 0) ? ST_GAP : ST_IDLE;
    localparam logic [CNT_W-1:0] GAP_LOAD = phase_load(GAP_CYCLES);
    localparam state_e          RD_STATE  = (READ_LATENCY != 0) ? ST_RD_WAIT : ST_SHIFT_IN;
    localparam logic [CNT_W-1:0] RD_LOAD  = (READ_LATENCY != 0) ? phase_load(READ_LATENCY)
                                                                 : CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] OUT_LOAD = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] IN_LOAD  = CNT_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic                ss_q, ss_d;
    logic                mosi_q, mosi_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic                load, shift_out, shift_in;
    logic                mosi_bit;
    logic [DATA_W-1:0]   rx_next;
    logic                accept;
    logic                in_frame;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != ST_IDLE);
    assign in_frame  = (state_q == ST_LEAD) || (state_q == ST_SHIFT_OUT) ||
                       (state_q == ST_RD_WAIT) || (state_q == ST_SHIFT_IN);

    assign SS_n      = ss_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    spi_master_shifter u_shifter (
        .clk_i       (CLK),
        .rst_i       (rst),
        .load_i      (load),
        .shift_out_i (shift_out),
        .shift_in_i  (shift_in),
        .cmd_i       (cmd_data),
        .miso_i      (MISO),
        .mosi_bit_o  (mosi_bit),
        .rx_next_o   (rx_next)
    );

    // NOTE: every signal gets a default before the case so no path can hold a
    // value implicitly and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        ss_d        = ss_q;
        mosi_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        load        = 1'b0;
        shift_out   = 1'b0;
        shift_in    = 1'b0;

        if (abort && in_frame) begin
            ss_d    = 1'b1;
            state_d = GAP_STATE;
            cnt_d   = GAP_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        load = 1'b1;
                        op_d = cmd_data[CMD_W-1 -: 2];
                        ss_d = 1'b0;
                        if (LEAD_CYCLES != 0) begin
                            state_d = ST_LEAD;
                            cnt_d   = phase_load(LEAD_CYCLES);
                        end else begin
                            state_d   = ST_SHIFT_OUT;
                            cnt_d     = OUT_LOAD;
                            shift_out = 1'b1;
                            mosi_d    = mosi_bit;
                        end
                    end
                end
                ST_LEAD: begin
                    if (cnt_q == '0) begin
                        state_d   = ST_SHIFT_OUT;
                        cnt_d     = OUT_LOAD;
                        shift_out = 1'b1;
                        mosi_d    = mosi_bit;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SHIFT_OUT: begin
                    if (cnt_q == '0) begin
                        if (op_q == OP_RD_DATA) begin
                            state_d = RD_STATE;
                            cnt_d   = RD_LOAD;
                        end else begin
                            ss_d    = 1'b1;
                            state_d = GAP_STATE;
                            cnt_d   = GAP_LOAD;
                        end
                    end else begin
                        cnt_d     = cnt_q - 1'b1;
                        shift_out = 1'b1;
                        mosi_d    = mosi_bit;
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SHIFT_IN;
                        cnt_d   = IN_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SHIFT_IN: begin
                    shift_in = 1'b1;
                    if (cnt_q == '0) begin
                        // The 8th MISO bit is folded in combinationally here.
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rx_next;
                        ss_d        = 1'b1;
                        state_d     = GAP_STATE;
                        cnt_d       = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    ss_d    = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_WR_ADDR;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule
